// File: rtl/ph_fifo_wr_arb.sv
// Write-port arbiter for the parasite-to-host FIFO: per-requester one-byte holding registers
// drained round-robin (or lowest-index-first when PH_ARB_FIXED_PRI_EN is defined) while the FIFO is not full.
module ph_fifo_wr_arb #(
    parameter int NREQ = 2,
    parameter int DW   = 8
) (
    input  logic              p_phi2,
    input  logic              h_rst_b,
    input  logic              flush,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    input  logic              fifo_full,
    output logic [DW-1:0]     fifo_din,
    output logic              fifo_wr_en,
    output logic [NREQ-1:0]   grant,
    output logic              busy
);
    localparam int PW = $clog2(NREQ);

    logic [NREQ-1:0] hold_valid;
    logic [DW-1:0]   hold_data [NREQ];
    logic [NREQ-1:0] eligible;
    logic [PW-1:0]   sel;
    logic            found;

`ifndef PH_ARB_FIXED_PRI_EN
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   rr_next;
`endif

    assign req_ready = ~hold_valid;
    assign busy      = |hold_valid;

    // Selection: first eligible index walking upward from the search base, wrapping at NREQ.
    always_comb begin
        logic [PW-1:0] cand;
        int            sum;
        eligible = fifo_full ? '0 : hold_valid;
        sel      = '0;
        found    = 1'b0;
        cand     = '0;
        sum      = 0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef PH_ARB_FIXED_PRI_EN
            sum = k;
`else
            sum = int'(rr_ptr) + k;
            if (sum >= NREQ) sum = sum - NREQ;
`endif
            cand = PW'(sum);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = found && (sel == PW'(i));
        end
        fifo_wr_en = found;
        fifo_din   = found ? hold_data[sel] : '0;
    end

`ifndef PH_ARB_FIXED_PRI_EN
    always_comb begin
        int nxt;
        nxt = int'(sel) + 1;
        if (nxt >= NREQ) nxt = 0;
        rr_next = PW'(nxt);
    end

    always_ff @(posedge p_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            rr_ptr <= '0;
        end else if (flush) begin
            rr_ptr <= '0;
        end else if (fifo_wr_en) begin
            rr_ptr <= rr_next;
        end
    end
`endif

    // Drain and accept never hit the same slot on one edge: drain needs valid, accept needs empty.
    always_ff @(posedge p_phi2 or negedge h_rst_b) begin
        if (!h_rst_b) begin
            hold_valid <= '0;
            for (int i = 0; i < NREQ; i++) begin
                hold_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (flush) begin
                    hold_valid[i] <= 1'b0;
                end else if (fifo_wr_en && (sel == PW'(i))) begin
                    hold_valid[i] <= 1'b0;
                end else if (req_valid[i] && !hold_valid[i]) begin
                    hold_valid[i] <= 1'b1;
                    hold_data[i]  <= req_data[i*DW +: DW];
                end
            end
        end
    end

endmodule

// File: tb/tb_ph_fifo_wr_arb.sv
// Bench for ph_fifo_wr_arb: directed scenarios plus random traffic against a queue-based reference model.
module tb_ph_fifo_wr_arb;
    localparam int NREQ = 3;
    localparam int DW   = 8;

    logic              p_phi2 = 1'b0;
    logic              h_rst_b = 1'b0;
    logic              flush = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              fifo_full = 1'b0;
    logic [DW-1:0]     fifo_din;
    logic              fifo_wr_en;
    logic [NREQ-1:0]   grant;
    logic              busy;

    ph_fifo_wr_arb #(.NREQ(NREQ), .DW(DW)) dut (
        .p_phi2    (p_phi2),
        .h_rst_b   (h_rst_b),
        .flush     (flush),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_din  (fifo_din),
        .fifo_wr_en(fifo_wr_en),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 p_phi2 = ~p_phi2;

    int checks = 0;
    int failures = 0;

    // Reference: each holding register is a queue of at most one byte; m_ptr is the search base.
    logic [DW-1:0] q [NREQ][$];
    int m_ptr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick();
        int base;
        int idx;
        if (fifo_full) return -1;
`ifdef PH_ARB_FIXED_PRI_EN
        base = 0;
`else
        base = m_ptr;
`endif
        for (int k = 0; k < NREQ; k++) begin
            idx = (base + k) % NREQ;
            if (q[idx].size() != 0) return idx;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        int w;
        logic [NREQ-1:0] eg;
        logic [NREQ-1:0] er;
        logic [DW-1:0]   ed;
        w  = pick();
        eg = '0;
        ed = '0;
        if (w >= 0) begin
            eg[w] = 1'b1;
            ed    = q[w][0];
        end
        for (int i = 0; i < NREQ; i++) er[i] = (q[i].size() == 0);
        chk("grant", 32'(grant), 32'(eg));
        chk("wr_en", 32'(fifo_wr_en), 32'(w >= 0));
        chk("din", 32'(fifo_din), 32'(ed));
        chk("ready", 32'(req_ready), 32'(er));
        chk("busy", 32'(busy), 32'(er != '1));
    endtask

    task automatic drive(input logic [NREQ-1:0] v, input logic [NREQ*DW-1:0] d,
                         input logic full, input logic fl);
        @(negedge p_phi2);
        req_valid = v;
        req_data  = d;
        fifo_full = full;
        flush     = fl;
        #1;
        check_outputs();
    endtask

    task automatic edge_update();
        int w;
        logic [NREQ-1:0] acc;
        @(posedge p_phi2);
        w = pick();
        for (int i = 0; i < NREQ; i++) acc[i] = req_valid[i] && (q[i].size() == 0);
        if (w >= 0) begin
            q[w].delete(0);
            m_ptr = (w + 1) % NREQ;
        end
        if (flush) begin
            for (int i = 0; i < NREQ; i++) q[i].delete();
            m_ptr = 0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (acc[i]) q[i].push_back(req_data[i*DW +: DW]);
        end
    endtask

    task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ*DW-1:0] d,
                         input logic full, input logic fl);
        drive(v, d, full, fl);
        edge_update();
    endtask

    initial begin
        logic [DW-1:0] seq [3];

        // Reset state
        h_rst_b = 1'b0;
        repeat (2) @(posedge p_phi2);
        @(negedge p_phi2);
        #1;
        chk("rst_ready", 32'(req_ready), 32'h7);
        chk("rst_wr_en", 32'(fifo_wr_en), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_din", 32'(fifo_din), 32'h0);
        h_rst_b = 1'b1;

        // Single byte
        cycle(3'b001, 24'h00005A, 1'b0, 1'b0);
        drive('0, '0, 1'b0, 1'b0);
        chk("single_wr_en", 32'(fifo_wr_en), 32'h1);
        chk("single_din", 32'(fifo_din), 32'h5A);
        chk("single_grant", 32'(grant), 32'h1);
        edge_update();
        drive('0, '0, 1'b0, 1'b0);
        chk("single_ready", 32'(req_ready[0]), 32'h1);
        chk("single_busy", 32'(busy), 32'h0);
        edge_update();

        // Contention from pointer 0 (flush first to return the pointer to 0)
        cycle('0, '0, 1'b0, 1'b1);
        cycle(3'b111, 24'h302010, 1'b1, 1'b0);
        seq[0] = 8'h10; seq[1] = 8'h20; seq[2] = 8'h30;
        for (int k = 0; k < 3; k++) begin
            drive('0, '0, 1'b0, 1'b0);
            chk("cont0_din", 32'(fifo_din), 32'(seq[k]));
            edge_update();
        end

        // Contention with the pointer left at 2 by a write from requester 1
        cycle(3'b010, 24'h002200, 1'b0, 1'b0);
        cycle('0, '0, 1'b0, 1'b0);
        cycle(3'b111, 24'h302010, 1'b1, 1'b0);
        seq[0] = 8'h30; seq[1] = 8'h10; seq[2] = 8'h20;
        for (int k = 0; k < 3; k++) begin
            drive('0, '0, 1'b0, 1'b0);
`ifndef PH_ARB_FIXED_PRI_EN
            chk("cont2_din", 32'(fifo_din), 32'(seq[k]));
`endif
            edge_update();
        end

        // Full backpressure
        cycle(3'b001, 24'h0000C3, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            drive('0, '0, 1'b1, 1'b0);
            chk("full_wr_en", 32'(fifo_wr_en), 32'h0);
            chk("full_ready0", 32'(req_ready[0]), 32'h0);
            edge_update();
        end
        drive('0, '0, 1'b0, 1'b0);
        chk("unfull_wr_en", 32'(fifo_wr_en), 32'h1);
        chk("unfull_din", 32'(fifo_din), 32'hC3);
        edge_update();
        drive('0, '0, 1'b0, 1'b0);
        chk("unfull_once", 32'(fifo_wr_en), 32'h0);
        edge_update();

        // Flush with a simultaneous offer from an empty requester
        cycle(3'b011, 24'h00BBAA, 1'b1, 1'b0);
        drive(3'b100, 24'h770000, 1'b1, 1'b1);
        edge_update();
        drive('0, '0, 1'b0, 1'b0);
        chk("flush_busy", 32'(busy), 32'h0);
        chk("flush_ready", 32'(req_ready), 32'h7);
        chk("flush_wr_en", 32'(fifo_wr_en), 32'h0);
        edge_update();
        cycle(3'b111, 24'h030201, 1'b1, 1'b0);
        repeat (4) cycle('0, '0, 1'b0, 1'b0);

        // Reset during an active write
        cycle(3'b010, 24'h004400, 1'b1, 1'b0);
        drive('0, '0, 1'b0, 1'b0);
        #1;
        h_rst_b = 1'b0;
        #1;
        chk("arst_wr_en", 32'(fifo_wr_en), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_grant", 32'(grant), 32'h0);
        chk("arst_ready", 32'(req_ready), 32'h7);
        for (int i = 0; i < NREQ; i++) q[i].delete();
        m_ptr = 0;
        @(posedge p_phi2);
        @(negedge p_phi2);
        h_rst_b = 1'b1;

        // Requester 0 refilling whenever free, requester 1 continuously offering
        for (int k = 0; k < 40; k++) cycle(3'b011, NREQ*DW'($urandom), 1'b0, 1'b0);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            cycle(NREQ'($urandom), NREQ*DW'($urandom),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ph_fifo_wr_arb.md
Name: ph_fifo_wr_arb

Overview:
Shares the single write port of the parasite-to-host FIFO between NREQ parasite-side requesters, for example the CPU data-register write path and a status/message generator. Each requester gets a one-byte holding register with a valid/ready handshake. A round-robin arbiter drains the holding registers into the FIFO and respects the FIFO full flag. The block sits on the parasite clock domain, directly in front of the FIFO write port.

Parameters:
NREQ, 2, number of requesters; legal range 2..4.
DW, 8, data width in bits.

Ports:
p_phi2  input  1  parasite clock; all state updates on the rising edge.
h_rst_b  input  1  asynchronous active-low reset.
flush  input  1  synchronous clear of all holding registers.
req_valid  input  NREQ  requester i offers req_data slice i.
req_data  input  NREQ*DW  requester i data in bits [i*DW +: DW].
req_ready  output  NREQ  requester i holding register is empty.
fifo_full  input  1  FIFO full flag, write-clock domain.
fifo_din  output  DW  data to the FIFO din.
fifo_wr_en  output  1  FIFO write enable.
grant  output  NREQ  one-hot; marks the requester being written this cycle.
busy  output  1  OR of all holding-register valid bits.

Behaviour:
- Reset (asynchronous, h_rst_b=0):
  - hold_valid = 0 for all requesters; hold_data = 0; rr_ptr = 0.
  - Consequence: req_ready = all ones, fifo_wr_en = 0, grant = 0, fifo_din = 0, busy = 0.
  - Reset asserted mid-transfer drops held bytes; fifo_wr_en falls with no clock edge needed.
- Accept:
  - req_ready[i] = ~hold_valid[i] (combinational from a register).
  - On an edge where req_valid[i] & req_ready[i]: hold_data[i] <= slice i, hold_valid[i] <= 1.
  - No same-cycle refill: a holding register drained on edge k can accept new data no earlier than edge k+1. Peak rate per requester is one byte per 2 cycles.
- Arbitration (combinational, from registered state):
  - eligible = hold_valid, masked to 0 when fifo_full = 1.
  - Selection: the first eligible index found by searching from rr_ptr upward, modulo NREQ.
  - grant = one-hot of the selection; fifo_wr_en = |grant; fifo_din = hold_data[selection], or 0 when nothing is granted.
- Drain:
  - On an edge with fifo_wr_en = 1: hold_valid[sel] <= 0, and rr_ptr <= (sel+1) mod NREQ.
  - rr_ptr is unchanged when no write occurs.
- Latency: a byte accepted on edge k is written into the FIFO on edge k+1 at the earliest, when uncontended and not full.
- Full:
  - While fifo_full = 1: no write, all holding registers retain their contents, and rr_ptr is frozen.
  - Requesters whose holding register is empty still accept.
  - The block never writes when full, so no byte is ever lost to overflow.
- flush:
  - On an edge with flush = 1: all hold_valid <= 0 and rr_ptr <= 0.
  - flush takes priority over accept on the same edge; writes combinationally enabled during that cycle still occur.
- Fairness: with all requesters continuously held, writes rotate 0,1,..,NREQ-1,0. No requester waits more than NREQ-1 writes.
- Ordering: per-requester order is preserved. Interleaving between requesters is defined solely by the arbitration rules above.

Optional Feature:
PH_ARB_FIXED_PRI_EN
- Defined: fixed priority, where the lowest eligible index always wins. rr_ptr is removed, and grant is independent of history.
- Undefined: round-robin as specified above.
- Handshake, full and flush behaviour are identical in both builds.

Test Plan:
1. Reset then idle: h_rst_b=0 -> req_ready=all ones, fifo_wr_en=0, grant=0, busy=0. Assert reset while hold_valid[1]=1 -> fifo_wr_en drops immediately, hold cleared.
2. Single byte, NREQ=2: req 0 valid with 0x5A on edge 1 -> cycle after edge 1: fifo_wr_en=1, fifo_din=0x5A, grant=01. After edge 2: req_ready[0]=1, busy=0.
3. Contention, NREQ=3, all holds loaded with 0x10/0x20/0x30 and rr_ptr=0 -> FIFO receives 0x10, 0x20, 0x30 on consecutive edges. Repeat with rr_ptr=2 -> order 0x30, 0x10, 0x20.
4. Full backpressure: hold 0 holds 0xC3 and fifo_full=1 for 5 cycles -> fifo_wr_en=0 throughout, rr_ptr unchanged, req_ready[0]=0. Full drops -> 0xC3 written on the next edge exactly once.
5. Flush: holds 0 and 1 valid, flush=1 for one edge -> busy=0, rr_ptr=0, no further writes. flush together with req_valid[0] on the same edge -> nothing captured.
6. Build with PH_ARB_FIXED_PRI_EN, NREQ=2, req 0 refilling every other cycle and req 1 continuously held -> every write alternates with req 0 taking precedence whenever eligible. Bench checks req 1 is granted only on cycles where hold_valid[0]=0.
